// File: rtl/ntt_bram_sched.sv
// In-place Cooley-Tukey NTT address sequencer for one coefficient BRAM.
// Ports: clk, reset (sync, active-high), start -> busy, done, raddr,
//   rd_first, bf_in_valid, tw_addr, wen, waddr (all registered).
module ntt_bram_sched #(
    parameter int LOGN = 8,
    parameter int LAT  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] raddr,
    output logic            rd_first,
    output logic            bf_in_valid,
    output logic [LOGN-1:0] tw_addr,
    output logic            wen,
    output logic [LOGN-1:0] waddr
);

    localparam int SW = $clog2(LOGN + 1);
    localparam logic [LOGN-1:0] KMAX  = {LOGN{1'b1}};
    localparam logic [SW-1:0]   SLAST = SW'(LOGN - 1);
    localparam logic [4:0]      DMAX  = 5'(LAT - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t state, state_n;

    logic [LOGN-1:0] k;
    logic [SW-1:0]   s;
    logic [4:0]      dcnt;

    logic            iss_v;
    logic [LOGN-1:0] iss_k;
    logic [SW-1:0]   iss_s;

    logic [SW-1:0]   sh;
    logic [LOGN-1:0] b, tbit, lo, hi;
    logic [LOGN-1:0] iss_addr, iss_tw;

    logic            rvalid;
    logic [LOGN-1:0] tw_q;

    logic [LAT-1:0]  dl_v;
    logic [LOGN-1:0] dl_a [LAT];

    // Next state plus the read to issue next cycle; outputs are
    // registered, so the issue decision is made one cycle ahead.
    always_comb begin
        state_n = state;
        iss_v   = 1'b0;
        iss_k   = '0;
        iss_s   = s;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = READ;
                    iss_v   = 1'b1;
                    iss_s   = '0;
                end
            end
            READ: begin
                if (k == KMAX) begin
                    state_n = DRAIN;
                end else begin
                    iss_v = 1'b1;
                    iss_k = k + LOGN'(1);
                end
            end
            DRAIN: begin
                if (dcnt == DMAX) begin
                    if (s == SLAST) begin
                        state_n = FIN;
                    end else begin
                        state_n = READ;
                        iss_v   = 1'b1;
                        iss_s   = s + SW'(1);
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Butterfly b = k>>1 splits into group (high bits) and j (low
    // sh bits); the operand address inserts k[0] at bit sh.
    always_comb begin
        sh       = SLAST - iss_s;
        b        = iss_k >> 1;
        tbit     = LOGN'(1) << sh;
        lo       = b & (tbit - LOGN'(1));
        hi       = (b >> sh) << (sh + SW'(1));
        iss_addr = hi | lo | (iss_k[0] ? tbit : '0);
        iss_tw   = (LOGN'(1) << iss_s) + (b >> sh);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k           <= '0;
            s           <= '0;
            dcnt        <= '0;
            rvalid      <= 1'b0;
            raddr       <= '0;
            rd_first    <= 1'b0;
            tw_q        <= '0;
            bf_in_valid <= 1'b0;
            tw_addr     <= '0;
            dl_v        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                dl_a[i] <= '0;
            end
        end else begin
            if (iss_v) begin
                k <= iss_k;
                s <= iss_s;
            end
            dcnt        <= (state == DRAIN) ? dcnt + 5'd1 : 5'd0;
            rvalid      <= iss_v;
            raddr       <= iss_v ? iss_addr : '0;
            rd_first    <= iss_v & ~iss_k[0];
            tw_q        <= iss_v ? iss_tw : '0;
            // dout carries i1 the cycle after the i1 read
            bf_in_valid <= rvalid & ~rd_first;
            tw_addr     <= (rvalid & ~rd_first) ? tw_q : '0;
            dl_v        <= {dl_v[LAT-2:0], rvalid};
            dl_a[0]     <= raddr;
            for (int i = 1; i < LAT; i++) begin
                dl_a[i] <= dl_a[i-1];
            end
            busy <= (state_n == READ) || (state_n == DRAIN);
            done <= (state_n == FIN);
        end
    end

    assign wen   = dl_v[LAT-1];
    assign waddr = dl_a[LAT-1];

endmodule

// File: tb/tb_ntt_bram_sched.sv
// Bench for ntt_bram_sched: small (LOGN=3,LAT=2) schedule tables and
// default (LOGN=8,LAT=4) transform against a reference NTT model.
module tb_ntt_bram_sched;

    localparam int Q   = 7681;
    localparam int N8  = 256;
    localparam int P8  = 260;
    localparam int MAXC = 2101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst3, start3, busy3, done3, rf3, bf3, wen3;
    logic [2:0] raddr3, tw3, waddr3;
    logic       rst8, start8, busy8, done8, rf8, bf8, wen8;
    logic [7:0] raddr8, tw8, waddr8;

    ntt_bram_sched #(.LOGN(3), .LAT(2)) u3 (
        .clk(clk), .reset(rst3), .start(start3),
        .busy(busy3), .done(done3), .raddr(raddr3),
        .rd_first(rf3), .bf_in_valid(bf3), .tw_addr(tw3),
        .wen(wen3), .waddr(waddr3)
    );

    ntt_bram_sched u8 (
        .clk(clk), .reset(rst8), .start(start8),
        .busy(busy8), .done(done8), .raddr(raddr8),
        .rd_first(rf8), .bf_in_valid(bf8), .tw_addr(tw8),
        .wen(wen8), .waddr(waddr8)
    );

    int errors = 0;
    int checks = 0;

    int rs  [3][8] = '{'{0,4,1,5,2,6,3,7},
                       '{0,2,1,3,4,6,5,7},
                       '{0,1,2,3,4,5,6,7}};
    int tws [3][4] = '{'{1,1,1,1}, '{2,2,3,3}, '{4,5,6,7}};

    // {ev, raddr, rd_first, bf, tw, wen, waddr, busy, done}
    function automatic logic [14:0] exp3(input int c);
        logic ev, rf, bf, ew, by, dn;
        logic [2:0] ra, tw, wa;
        int o;
        ev = 0; rf = 0; bf = 0; ew = 0;
        ra = 0; tw = 0; wa = 0;
        by = (c >= 1 && c <= 30);
        dn = (c == 31);
        if (c >= 1 && c <= 30) begin
            o = (c - 1) % 10;
            if (o < 8) begin
                ev = 1; ra = 3'(rs[(c-1)/10][o]); rf = (o % 2 == 0);
            end
        end
        if (c >= 2 && c <= 31) begin
            o = (c - 2) % 10;
            if (o < 8 && o % 2 == 1) begin
                bf = 1; tw = 3'(tws[(c-2)/10][o/2]);
            end
        end
        if (c >= 3 && c <= 32) begin
            o = (c - 3) % 10;
            if (o < 8) begin
                ew = 1; wa = 3'(rs[(c-3)/10][o]);
            end
        end
        return {ev, ra, rf, bf, tw, ew, wa, by, dn};
    endfunction

    // Coefficient BRAM + butterfly model for the default instance.
    int mem8 [N8];
    int refm [N8];
    int twt  [N8];
    int wq [$];
    int dprev = 0, dcur = 0, dnext, qerr = 0;

    always @(negedge clk) begin
        int u, v;
        if (bf8 === 1'b1) begin
            u = dprev;
            v = (dcur * twt[tw8]) % Q;
            wq.push_back((u + v) % Q);
            wq.push_back((u + Q - v) % Q);
        end
        dnext = mem8[raddr8];
        if (wen8 === 1'b1) begin
            if (wq.size() == 0) qerr++;
            else mem8[waddr8] = wq.pop_front();
        end
        dprev = dcur;
        dcur  = dnext;
    end

    logic ev8 [MAXC], erf8 [MAXC], ebf8 [MAXC], ewn8 [MAXC];
    int   era8 [MAXC], etw8 [MAXC], ewa8 [MAXC];

    task automatic test_reset();
        rst3 = 1; rst8 = 1; start3 = 0; start8 = 0;
        repeat (3) @(negedge clk);
        rst3 = 0; rst8 = 0;
        checks++;
        if ({busy3, done3, raddr3, rf3, bf3, tw3, wen3, waddr3} !== 14'd0) begin
            errors++;
            $display("FAIL reset3: got %b want 0",
                     {busy3, done3, raddr3, rf3, bf3, tw3, wen3, waddr3});
        end
        checks++;
        if ({busy8, done8, raddr8, rf8, bf8, tw8, wen8, waddr8} !== 29'd0) begin
            errors++;
            $display("FAIL reset8: got %h want 0",
                     {busy8, done8, raddr8, rf8, bf8, tw8, wen8, waddr8});
        end
    endtask

    // Called at the negedge of relative cycle 0.
    task automatic run3(input string nm);
        logic [14:0] e, a;
        start3 = 1;
        @(negedge clk);
        start3 = 0;
        for (int c = 1; c <= 34; c++) begin
            e = exp3(c);
            a = {e[14], e[14] ? raddr3 : 3'd0, rf3, bf3,
                 e[9] ? tw3 : 3'd0, wen3, e[5] ? waddr3 : 3'd0,
                 busy3, done3};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s c=%0d: got %b want %b", nm, c, a, e);
            end
            if (e[14] && wen3) begin
                checks++;
                if (raddr3 === waddr3) begin
                    errors++;
                    $display("FAIL %s hazard c=%0d: raddr %0d waddr %0d",
                             nm, c, raddr3, waddr3);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_schedule3();
        run3("sched3");
    endtask

    task automatic test_reset_mid();
        logic [14:0] e, a;
        start3 = 1;
        @(negedge clk);
        start3 = 0;
        for (int c = 1; c <= 15; c++) begin
            e = exp3(c);
            a = {e[14], e[14] ? raddr3 : 3'd0, rf3, bf3,
                 e[9] ? tw3 : 3'd0, wen3, e[5] ? waddr3 : 3'd0,
                 busy3, done3};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL pre_rst c=%0d: got %b want %b", c, a, e);
            end
            if (c == 15) rst3 = 1;
            @(negedge clk);
        end
        rst3 = 0;
        for (int c = 16; c <= 19; c++) begin
            checks++;
            if ({busy3, done3, raddr3, rf3, bf3, tw3, wen3, waddr3} !== 14'd0) begin
                errors++;
                $display("FAIL post_rst c=%0d: got %b want 0", c,
                         {busy3, done3, raddr3, rf3, bf3, tw3, wen3, waddr3});
            end
            @(negedge clk);
        end
        run3("restart");
    endtask

    task automatic run8(input string nm, input bit inject, input int last_c);
        int c, t, mism, nd, dcyc, bad, u, v;
        for (int i = 0; i < MAXC; i++) begin
            ev8[i] = 0; erf8[i] = 0; ebf8[i] = 0; ewn8[i] = 0;
            era8[i] = 0; etw8[i] = 0; ewa8[i] = 0;
        end
        for (int s = 0; s < 8; s++) begin
            t = N8 >> (s + 1);
            c = 1 + s * P8;
            for (int g = 0; g < N8 / (2 * t); g++) begin
                for (int j = 0; j < t; j++) begin
                    ev8[c] = 1; erf8[c] = 1; era8[c] = g * 2 * t + j;
                    ev8[c+1] = 1; era8[c+1] = g * 2 * t + j + t;
                    ebf8[c+2] = 1; etw8[c+2] = (1 << s) + g;
                    ewn8[c+4] = 1; ewa8[c+4] = era8[c];
                    ewn8[c+5] = 1; ewa8[c+5] = era8[c+1];
                    c += 2;
                end
            end
        end
        for (int i = 0; i < N8; i++) refm[i] = mem8[i];
        for (int s = 0; s < 8; s++) begin
            t = N8 >> (s + 1);
            for (int g = 0; g < N8 / (2 * t); g++) begin
                for (int j = 0; j < t; j++) begin
                    u = refm[g*2*t + j];
                    v = (refm[g*2*t + j + t] * twt[(1 << s) + g]) % Q;
                    refm[g*2*t + j]     = (u + v) % Q;
                    refm[g*2*t + j + t] = (u + Q - v) % Q;
                end
            end
        end
        mism = 0; nd = 0; dcyc = -1; bad = 0;
        start8 = 1;
        @(negedge clk);
        start8 = 0;
        for (int cc = 1; cc <= last_c; cc++) begin
            start8 = inject && (cc == 5 || cc == 40);
            if (rf8 !== erf8[cc] || (ev8[cc] && raddr8 !== 8'(era8[cc])) ||
                bf8 !== ebf8[cc] || (ebf8[cc] && tw8 !== 8'(etw8[cc])) ||
                wen8 !== ewn8[cc] || (ewn8[cc] && waddr8 !== 8'(ewa8[cc])) ||
                busy8 !== (cc <= 2080) ||
                (ev8[cc] && wen8 && raddr8 === waddr8))
                mism++;
            if (done8 === 1'b1) begin
                nd++; dcyc = cc;
            end
            @(negedge clk);
        end
        start8 = 0;
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL %s sched: %0d bad cycles, want 0", nm, mism);
        end
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d want 1", nm, nd);
        end
        checks++;
        if (dcyc != 2081) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d want 2081", nm, dcyc);
        end
        for (int i = 0; i < N8; i++) if (mem8[i] != refm[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s bram: %0d words differ, want 0", nm, bad);
        end
        checks++;
        if (wq.size() != 0 || qerr != 0) begin
            errors++;
            $display("FAIL %s wb_queue: left %0d underflow %0d want 0 0",
                     nm, wq.size(), qerr);
        end
    endtask

    task automatic test_ntt8();
        run8("ntt8", 1'b0, 2081);
    endtask

    task automatic test_back_to_back();
        run8("b2b_ign", 1'b1, 2100);
    endtask

    initial begin
        for (int i = 0; i < N8; i++) begin
            mem8[i] = (i * 13 + 5) % Q;
            twt[i]  = (i * 37 + 11) % Q;
        end
        test_reset();
        test_schedule3();
        test_reset_mid();
        test_ntt8();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
